phoneme_player: RTL and testbench
=================================

PHONEME_PLAYER -- requirements
Module: phoneme_player

Interface
REQ-001 Parameter NUM_PHONEMES, default 64, number of valid phoneme table entries.
REQ-002 Parameter ADDR_W, default 23, flash word-address width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level request from the controller (its start_fsm register); a rising edge launches playback.
REQ-006 phoneme_sel  input  8  phoneme index; sampled on the cycle the start rising edge is detected.
REQ-007 sample_en  input  1  one-cycle audio-rate strobe (e.g. 22 kHz) pacing sample output.
REQ-008 mem_addr  output  ADDR_W  flash word address.
REQ-009 mem_read  output  1  read request, held until accepted.
REQ-010 mem_waitrequest  input  1  memory stall; request is accepted on a cycle with mem_read=1 and mem_waitrequest=0.
REQ-011 mem_readdatavalid  input  1  one-cycle strobe qualifying mem_readdata.
REQ-012 mem_readdata  input  32  four 8-bit samples; byte 0 [7:0] is played first.
REQ-013 audio_out  output  8  current sample, signed two's complement.
REQ-014 busy  output  1  high from start acceptance until done is raised.
REQ-015 done  output  1  finish flag read back by the controller's input port 0.

Function
REQ-016 States SHALL be: IDLE, LOOKUP, REQ, WAIT, PLAY, FINISH.
REQ-017 IDLE: when start is 1 and was 0 in the previous cycle, latch phoneme_sel, clear done, set busy, go to LOOKUP.
REQ-018 LOOKUP: one cycle; read start_addr/end_addr for the latched index from the table. An index >= NUM_PHONEMES goes directly to FINISH with no memory access.
REQ-019 REQ: drive mem_addr=cur_addr and mem_read=1; on acceptance, drop mem_read and go to WAIT.
REQ-020 WAIT: on mem_readdatavalid, latch the word, set byte_idx=0, go to PLAY. mem_readdatavalid in any other state SHALL be ignored.
REQ-021 PLAY: on each sample_en, audio_out <= byte[byte_idx] and byte_idx increments.
REQ-022 After byte 3 is output: if cur_addr==end_addr, go to FINISH; else cur_addr+1 and go to REQ.
REQ-023 end_addr is inclusive; start_addr==end_addr plays exactly 4 samples.
REQ-024 Between words, audio_out SHALL hold its last value. No sample_en is lost by buffering; sample_en outside PLAY is ignored.
REQ-025 FINISH: one cycle; set done=1, clear busy, set audio_out=0, go to IDLE.
REQ-026 done SHALL stay 1 until the next accepted start edge.
REQ-027 A start that is held high or re-asserted while busy SHALL be ignored; only an edge seen in IDLE launches playback. A start edge on the same cycle as FINISH is not accepted.
REQ-028 cur_addr SHALL wrap modulo 2^ADDR_W; there is no overflow flag.

Reset
REQ-029 When rst_n=0 at a clock edge: state=IDLE, audio_out=0, busy=0, done=0, mem_read=0, mem_addr=0, byte_idx=0, start-edge history=1.
REQ-030 Setting start-edge history to 1 means a start held high through reset does not trigger playback.
REQ-031 Reset mid-transaction SHALL abandon any outstanding read; a late mem_readdatavalid arriving in IDLE is ignored.

Structure
REQ-032 Package phoneme_pkg SHALL hold: the state encoding, NUM_PHONEMES, ADDR_W, and the sample-width constant (8).
REQ-033 Sub-module phoneme_addr_rom: combinational or one-cycle registered lookup, index in, {start_addr, end_addr} out, contents from an init file. LOOKUP timing SHALL absorb a one-cycle ROM latency.

Verification
REQ-034 Table entry 5 = {0x100, 0x101}; start rises with phoneme_sel=5, memory returns 0x44332211 and 0x88776655 -> audio_out sequence 11,22,33,44,55,66,77,88 on successive sample_en; done=1 after the 8th sample; mem_read issued exactly twice.
REQ-035 mem_waitrequest held for 5 cycles -> mem_read and mem_addr=0x100 stay stable for those 5 cycles; one read is accepted.
REQ-036 phoneme_sel=0xFF -> no mem_read; done=1 within 3 cycles of the start edge; audio_out=0.
REQ-037 start held high after done, then a second rise with phoneme_sel=5 -> exactly one new playback; done cleared on the accepting cycle.
REQ-038 rst_n=0 during WAIT, with readdatavalid arriving 2 cycles later -> all outputs at reset values; no sample output; state IDLE.
REQ-039 Entry {0x7FFFFF, 0x000000} -> two reads, at 0x7FFFFF then 0x000000 (wrap); done after 8 samples.

Source files
------------

// File: rtl/phoneme_pkg.sv
// Shared constants, FSM encoding and sample extraction helper for the phoneme player.
// Flash words carry four 8-bit samples, lowest byte played first.
package phoneme_pkg;

   localparam int NUM_PHONEMES = 64;
   localparam int ADDR_W       = 23;
   localparam int SAMPLE_W     = 8;
   localparam int WORD_W       = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REQ,
      WAIT,
      PLAY,
      FINISH
   } state_t;

   function automatic logic [SAMPLE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                      input logic [1:0]        idx);
      return SAMPLE_W'(w >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/phoneme_addr_rom.sv
// Phoneme address table: index in, inclusive {start_addr, end_addr} flash word range out.
// One-cycle registered lookup; out-of-range indices report hit=0 and a zero range.
module phoneme_addr_rom #(
   parameter int NUM_PHONEMES = phoneme_pkg::NUM_PHONEMES,
   parameter int ADDR_W       = phoneme_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic [7:0]        idx,
   output logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] end_addr,
   output logic              hit
);
   import phoneme_pkg::*;

   // Table contents: two hand-placed entries, the rest laid out at 16-word strides
   // with lengths of 1 to 3 words.
   function automatic logic [2*ADDR_W-1:0] table_entry(input logic [7:0] i);
      logic [ADDR_W-1:0] s;
      logic [ADDR_W-1:0] e;
      case (i)
         8'd5: begin
            s = ADDR_W'(32'h0000_0100);
            e = ADDR_W'(32'h0000_0101);
         end
         8'd6: begin
            s = ADDR_W'(32'h007F_FFFF);
            e = '0;
         end
         default: begin
            s = ADDR_W'({24'd0, i} << 4);
            e = s + ADDR_W'(i % 8'd3);
         end
      endcase
      return {s, e};
   endfunction

   always_ff @(posedge clk) begin
      if (32'(idx) < NUM_PHONEMES) begin
         {start_addr, end_addr} <= table_entry(idx);
         hit                    <= 1'b1;
      end else begin
         start_addr <= '0;
         end_addr   <= '0;
         hit        <= 1'b0;
      end
   end

endmodule

// File: rtl/phoneme_player.sv
// Plays a phoneme: looks up its flash word range, fetches words one at a time and
// emits four signed 8-bit samples per word on successive sample_en strobes.
module phoneme_player #(
   parameter int NUM_PHONEMES = phoneme_pkg::NUM_PHONEMES,
   parameter int ADDR_W       = phoneme_pkg::ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [7:0]                    phoneme_sel,
   input  logic                          sample_en,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_read,
   input  logic                          mem_waitrequest,
   input  logic                          mem_readdatavalid,
   input  logic [31:0]                   mem_readdata,
   output logic [phoneme_pkg::SAMPLE_W-1:0] audio_out,
   output logic                          busy,
   output logic                          done
);
   import phoneme_pkg::*;

   state_t            state_q;
   state_t            state_d;
   logic              start_q;
   logic [7:0]        idx_q;
   logic [7:0]        rom_idx;
   logic [ADDR_W-1:0] rom_start;
   logic [ADDR_W-1:0] rom_end;
   logic              rom_hit;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [WORD_W-1:0] word_q;
   logic [1:0]        byte_idx;
   logic              start_edge;
   logic              last_sample;
   logic              last_word;

   assign start_edge  = start & ~start_q;
   assign last_sample = sample_en && (byte_idx == 2'd3);
   assign last_word   = (cur_addr == end_addr);

   // The ROM samples phoneme_sel directly while idle so its registered output is
   // already valid during LOOKUP; afterwards it keeps looking at the latched index.
   assign rom_idx = (state_q == IDLE) ? phoneme_sel : idx_q;

   phoneme_addr_rom #(
      .NUM_PHONEMES (NUM_PHONEMES),
      .ADDR_W       (ADDR_W)
   ) u_rom (
      .clk        (clk),
      .idx        (rom_idx),
      .start_addr (rom_start),
      .end_addr   (rom_end),
      .hit        (rom_hit)
   );

   assign mem_read = (state_q == REQ);
   assign mem_addr = cur_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_edge) state_d = LOOKUP;
         LOOKUP:  state_d = rom_hit ? REQ : FINISH;
         REQ:     if (!mem_waitrequest) state_d = WAIT;
         WAIT:    if (mem_readdatavalid) state_d = PLAY;
         PLAY:    if (last_sample) state_d = last_word ? FINISH : REQ;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q   <= 1'b1;
         idx_q     <= '0;
         cur_addr  <= '0;
         end_addr  <= '0;
         word_q    <= '0;
         byte_idx  <= '0;
         audio_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               if (start_edge) begin
                  idx_q <= phoneme_sel;
                  done  <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            LOOKUP: begin
               cur_addr <= rom_start;
               end_addr <= rom_end;
            end
            WAIT: begin
               if (mem_readdatavalid) begin
                  word_q   <= mem_readdata;
                  byte_idx <= 2'd0;
               end
            end
            PLAY: begin
               if (sample_en) begin
                  audio_out <= word_byte(word_q, byte_idx);
                  byte_idx  <= byte_idx + 2'd1;
                  // Address wraps naturally at 2^ADDR_W.
                  if (last_sample && !last_word) cur_addr <= cur_addr + ADDR_W'(1);
               end
            end
            FINISH: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               audio_out <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_phoneme_player.sv
// Randomised bench for phoneme_player with a flash responder and a word-level playback model.
module tb_phoneme_player;
   localparam int NP = 64;
   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b1;
   logic [7:0]    phoneme_sel = 8'd0;
   logic          sample_en = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_read;
   logic          mem_waitrequest = 1'b0;
   logic          mem_readdatavalid = 1'b0;
   logic [31:0]   mem_readdata = 32'd0;
   logic [7:0]    audio_out;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   phoneme_player #(.NUM_PHONEMES(NP), .ADDR_W(AW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .phoneme_sel       (phoneme_sel),
      .sample_en         (sample_en),
      .mem_addr          (mem_addr),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_readdata      (mem_readdata),
      .audio_out         (audio_out),
      .busy              (busy),
      .done              (done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // responder controls and observations
   int            stall_setting = 0;
   bit            rand_stall = 1'b0;
   bit            drop_resp = 1'b0;
   bit            manual_rdv = 1'b0;
   int            stall_left = 0;
   bit            req_active = 1'b0;
   logic [AW-1:0] req_addr = '0;
   int            stall_cycles = 0;
   int            stall_bad = 0;
   int            resp_cnt = -1;
   logic [AW-1:0] resp_addr = '0;
   logic [AW-1:0] reads[$];
   logic [7:0]    trace[$];
   logic [7:0]    last_audio = 8'd0;
   bit            rec_on = 1'b0;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      if (a == 23'h100) return 32'h4433_2211;
      if (a == 23'h101) return 32'h8877_6655;
      return ({9'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic get_entry(input int sel, output bit valid,
                            output logic [AW-1:0] s, output logic [AW-1:0] e);
      valid = (sel < NP);
      if (sel == 5) begin s = 23'h100; e = 23'h101; end
      else if (sel == 6) begin s = 23'h7FFFFF; e = 23'h0; end
      else begin s = AW'(sel * 16); e = s + AW'(sel % 3); end
   endtask

   // Flash responder, sample strobe generator and audio trace recorder.
   initial begin : responder
      forever begin
         @(posedge clk); #1;
         sample_en = ($urandom_range(0, 2) == 0);
         if (rec_on && audio_out !== last_audio) begin
            trace.push_back(audio_out);
            last_audio = audio_out;
         end
         if (!manual_rdv) begin
            mem_readdatavalid = 1'b0;
            if (resp_cnt == 0) begin
               mem_readdatavalid = 1'b1;
               mem_readdata      = mem_word(resp_addr);
               resp_cnt          = -1;
            end else if (resp_cnt > 0) begin
               resp_cnt--;
            end
         end
         mem_waitrequest = 1'b0;
         if (mem_read === 1'b1) begin
            if (!req_active) begin
               req_active = 1'b1;
               req_addr   = mem_addr;
               stall_left = rand_stall ? int'($urandom_range(0, 3)) : stall_setting;
            end
            if (mem_addr !== req_addr) stall_bad++;
            if (stall_left > 0) begin
               mem_waitrequest = 1'b1;
               stall_left--;
               stall_cycles++;
            end else begin
               req_active = 1'b0;
               reads.push_back(mem_addr);
               resp_addr = mem_addr;
               if (!drop_resp) resp_cnt = $urandom_range(0, 2);
            end
         end else if (req_active) begin
            stall_bad++;
            req_active = 1'b0;
         end
      end
   end

   // Launch one playback and compare reads and the audio trace against the model.
   task automatic play(input int sel, input string tag);
      bit            v;
      logic [AW-1:0] s, e, d, a;
      logic [31:0]   w;
      logic [AW-1:0] exp_reads[$];
      logic [7:0]    raw[$];
      logic [7:0]    exp_trace[$];
      int            nw;
      int            cyc;
      get_entry(sel, v, s, e);
      raw.push_back(8'h00);
      if (v) begin
         d  = e - s;
         nw = int'(d) + 1;
         a  = s;
         for (int k = 0; k < nw; k++) begin
            exp_reads.push_back(a);
            w = mem_word(a);
            for (int b = 0; b < 4; b++) raw.push_back(w[8*b +: 8]);
            a = a + AW'(1);
         end
      end
      raw.push_back(8'h00);
      foreach (raw[i]) if (i == 0 || raw[i] !== raw[i-1]) exp_trace.push_back(raw[i]);

      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reads.delete();
      trace.delete();
      trace.push_back(audio_out);
      last_audio  = audio_out;
      rec_on      = 1'b1;
      phoneme_sel = 8'(sel);
      start       = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", tag, busy, done);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (cyc >= 3000 || (!v && cyc > 2)) begin
         n_bad++;
         $display("FAIL %s done_timing: took %0d cycles after accept, limit %0d", tag, cyc, v ? 2999 : 2);
      end
      @(posedge clk); #1;
      rec_on = 1'b0;
      n_cmp++;
      if (reads.size() != exp_reads.size()) begin
         n_bad++;
         $display("FAIL %s read_count: got %0d want %0d", tag, reads.size(), exp_reads.size());
      end else begin
         foreach (exp_reads[i]) begin
            n_cmp++;
            if (reads[i] !== exp_reads[i]) begin
               n_bad++;
               $display("FAIL %s read_addr[%0d]: got %h want %h", tag, i, reads[i], exp_reads[i]);
            end
         end
      end
      n_cmp++;
      if (trace.size() != exp_trace.size()) begin
         n_bad++;
         $display("FAIL %s trace_len: got %0d want %0d", tag, trace.size(), exp_trace.size());
      end else begin
         foreach (exp_trace[i]) begin
            n_cmp++;
            if (trace[i] !== exp_trace[i]) begin
               n_bad++;
               $display("FAIL %s sample[%0d]: got %h want %h", tag, i, trace[i], exp_trace[i]);
            end
         end
      end
      n_cmp++;
      if (audio_out !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL %s end_state: audio=%h busy=%b done=%b, want 00/0/1", tag, audio_out, busy, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (audio_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_values: audio=%h busy=%b done=%b rd=%b addr=%h, want all zero",
                  audio_out, busy, done, mem_read, mem_addr);
      end
      rst_n = 1'b1;
      reads.delete();
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || reads.size() != 0) begin
         n_bad++;
         $display("FAIL reset_start_held: busy=%b reads=%0d, want 0/0", busy, reads.size());
      end
   endtask

   task automatic test_basic();
      logic [7:0] lit[10];
      lit = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      play(5, "basic");
      n_cmp++;
      if (trace.size() != 10 || reads.size() != 2) begin
         n_bad++;
         $display("FAIL basic_literal: trace=%0d reads=%0d, want 10/2", trace.size(), reads.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (trace[i] !== lit[i]) begin
               n_bad++;
               $display("FAIL basic_literal[%0d]: got %h want %h", i, trace[i], lit[i]);
            end
         end
      end
   endtask

   task automatic test_waitrequest();
      stall_setting = 5;
      stall_cycles  = 0;
      stall_bad     = 0;
      play(5, "stall");
      n_cmp++;
      if (stall_cycles != 10 || stall_bad != 0) begin
         n_bad++;
         $display("FAIL stall_hold: stall_cycles=%0d unstable=%0d, want 10/0", stall_cycles, stall_bad);
      end
      stall_setting = 0;
   endtask

   task automatic test_invalid();
      play(255, "idx_ff");
      play(64, "idx_64");
      play(63, "idx_63");
   endtask

   task automatic test_finish_edge();
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reads.delete();
      phoneme_sel = 8'hFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      phoneme_sel = 8'd5;
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL finish_edge_done: done=%b want 1", done);
      end
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || reads.size() != 0) begin
         n_bad++;
         $display("FAIL finish_edge_ignored: busy=%b done=%b reads=%0d, want 0/1/0", busy, done, reads.size());
      end
   endtask

   task automatic test_restart();
      reads.delete();
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || reads.size() != 0) begin
         n_bad++;
         $display("FAIL held_start: busy=%b done=%b reads=%0d, want 0/1/0", busy, done, reads.size());
      end
      play(5, "restart");
      reads.delete();
      repeat (30) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || reads.size() != 0) begin
         n_bad++;
         $display("FAIL single_playback: busy=%b extra_reads=%0d, want 0/0", busy, reads.size());
      end
   endtask

   task automatic test_wrap();
      play(6, "wrap");
   endtask

   task automatic test_random();
      rand_stall = 1'b1;
      for (int n = 0; n < 12; n++) play(int'($urandom_range(0, 70)), "random");
      rand_stall = 1'b0;
   endtask

   task automatic test_reset_wait();
      int cyc;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      drop_resp = 1'b1;
      reads.delete();
      phoneme_sel = 8'd5;
      start = 1'b1;
      cyc = 0;
      while (reads.size() == 0 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (reads.size() != 1) begin
         n_bad++;
         $display("FAIL rst_wait_req: reads=%0d want 1", reads.size());
      end
      @(posedge clk); #1;
      manual_rdv = 1'b1;
      rst_n = 1'b0;
      trace.delete();
      last_audio = audio_out;
      rec_on = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_readdatavalid = 1'b1;
      mem_readdata = 32'h4433_2211;
      @(posedge clk); #1;
      mem_readdatavalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (audio_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_outputs[%0d]: audio=%h busy=%b done=%b rd=%b addr=%h, want zeros",
                     i, audio_out, busy, done, mem_read, mem_addr);
         end
      end
      rec_on = 1'b0;
      n_cmp++;
      if (trace.size() != 0 || reads.size() != 1) begin
         n_bad++;
         $display("FAIL rst_wait_quiet: samples=%0d reads=%0d, want 0/1", trace.size(), reads.size());
      end
      manual_rdv = 1'b0;
      drop_resp  = 1'b0;
      resp_cnt   = -1;
      req_active = 1'b0;
      play(5, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_waitrequest();
      test_invalid();
      test_finish_edge();
      test_restart();
      test_wrap();
      test_random();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
